// File: rtl/lsu_pkg.sv
// Shared constants, state type and helpers for the load/store data memory.
package lsu_pkg;

   localparam logic [2:0] OP_B  = 3'b000;
   localparam logic [2:0] OP_H  = 3'b001;
   localparam logic [2:0] OP_W  = 3'b010;
   localparam logic [2:0] OP_D  = 3'b011;
   localparam logic [2:0] OP_BU = 3'b100;
   localparam logic [2:0] OP_HU = 3'b101;
   localparam logic [2:0] OP_WU = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } lsu_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) r++;
      return r;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between an XLEN-bit array word and a sized, LSB-aligned access.
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter  int unsigned XLEN = 32,
   localparam int unsigned NB   = XLEN / 8,
   localparam int unsigned LB   = clog2(NB)
) (
   input  logic [2:0]      mem_op,
   input  logic [LB-1:0]   lane,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rword,
   output logic [NB-1:0]   be_c,
   output logic [XLEN-1:0] wdata_sh_c,
   output logic [XLEN-1:0] rdata_c,
   output logic            misaligned_c
);

   logic [3:0]      size_b;
   logic [LB+2:0]   sh_amt;
   logic [XLEN-1:0] rshift;
   logic [XLEN-1:0] keep_mask;
   logic            sign_bit;

   always_comb begin
      size_b       = 4'd1 << mem_op[1:0];
      sh_amt       = {lane, 3'b000};
      be_c         = NB'(NB'((16'd1 << size_b) - 16'd1) << lane);
      wdata_sh_c   = wdata << sh_amt;
      rshift       = rword >> sh_amt;
      keep_mask    = '1;
      sign_bit     = rshift[XLEN-1];
      case (mem_op[1:0])
         2'd0: begin
            keep_mask = XLEN'(8'hFF);
            sign_bit  = rshift[7];
         end
         2'd1: begin
            keep_mask = XLEN'(16'hFFFF);
            sign_bit  = rshift[15];
         end
         2'd2: begin
            keep_mask = XLEN'(32'hFFFF_FFFF);
            sign_bit  = rshift[31];
         end
         default: ;
      endcase
      // unsigned ops (mem_op[2]) zero-fill above the access, signed ops replicate its top bit
      rdata_c      = (rshift & keep_mask) | ((sign_bit && !mem_op[2]) ? ~keep_mask : '0);
      misaligned_c = |(lane & LB'(size_b - 4'd1));
   end

endmodule

// File: rtl/lsu_data_mem.sv
// Load/store data memory: one outstanding access, valid/ready request and response
// channels, byte-lane alignment and fault reporting, LATENCY-cycle response.
module lsu_data_mem
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned LATENCY   = 1,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic            ReqValid,
   output logic            ReqReady,
   input  logic [31:0]     ReqAddr,
   input  logic            ReqWr,
   input  logic [2:0]      MemOp,
   input  logic [XLEN-1:0] ReqWData,
   output logic            RspValid,
   input  logic            RspReady,
   output logic [XLEN-1:0] RspRData,
   output logic            RspFault
);

   localparam int unsigned NB     = XLEN / 8;
   localparam int unsigned LB     = clog2(NB);
   localparam int unsigned AW     = (DEPTH > 1) ? clog2(DEPTH) : 1;
   localparam logic [2:0]  LAT_M1 = 3'(LATENCY - 1);

   lsu_state_e      state_q, state_d, launch_state;
   logic [2:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            fault_q, fault_d;

   logic [XLEN-1:0] mem [DEPTH];

   logic [31:0]     off;
   logic [31:0]     word;
   logic [AW-1:0]   word_idx;
   logic [LB-1:0]   lane;
   logic            illegal, out_of_range, misaligned, fault;
   logic            accept, mem_we;
   logic [NB-1:0]   be;
   logic [XLEN-1:0] wdata_sh, rdata_ext, rword;

   lsu_lane_align #(.XLEN(XLEN)) u_align (
      .mem_op       (MemOp),
      .lane         (lane),
      .wdata        (ReqWData),
      .rword        (rword),
      .be_c         (be),
      .wdata_sh_c   (wdata_sh),
      .rdata_c      (rdata_ext),
      .misaligned_c (misaligned)
   );

   // Address decode and fault classification for the request on the bus.
   always_comb begin
      off          = ReqAddr - BASE_ADDR;
      word         = off >> LB;
      word_idx     = AW'(word);
      lane         = off[LB-1:0];
      rword        = mem[word_idx];
      illegal      = (XLEN == 32 && MemOp[1:0] == 2'd3) ||
                     (MemOp[2] && ReqWr) ||
                     (MemOp[2] && (32'd1 << MemOp[1:0]) == 32'(NB));
      out_of_range = (ReqAddr < BASE_ADDR) || (word >= 32'(DEPTH));
      fault        = illegal || misaligned || out_of_range;
      ReqReady     = Rst_n && ((state_q == IDLE) || (state_q == RESP && RspReady));
      accept       = ReqValid && ReqReady;
      mem_we       = accept && ReqWr && !fault;
      launch_state = (LATENCY == 1) ? RESP : WAIT;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      // Response is captured at acceptance and only presented once RESP is reached.
      if (accept) begin
         rdata_d = (fault || ReqWr) ? '0 : rdata_ext;
         fault_d = fault;
      end
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = launch_state;
               cnt_d   = LAT_M1;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = RESP;
         end
         RESP: begin
            if (RspReady) begin
               if (accept) begin
                  state_d = launch_state;
                  cnt_d   = LAT_M1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
      end
   end

   // Array contents survive reset; only enabled byte lanes are written.
   always_ff @(posedge Clk) begin
      for (int b = 0; b < NB; b++) begin
         if (mem_we && be[b]) mem[word_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
      end
   end

   assign RspValid = (state_q == RESP);
   assign RspRData = rdata_q;
   assign RspFault = fault_q;

endmodule

// File: tb/tb_lsu_data_mem.sv
// Bench for lsu_data_mem: four instances (XLEN 32 at latency 1/3/4, XLEN 64 at latency 2)
// checked against a byte-addressed reference memory, plus directed literal expectations.
module tb_lsu_data_mem;
   import lsu_pkg::*;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int unsigned DEPTH = 1024;

   typedef struct {
      logic [63:0] rd;
      logic        f;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic [3:0]  rst_n, req_valid, req_wr, rsp_ready;
   wire  [3:0]  req_ready, rsp_valid, rsp_fault;
   logic [31:0] req_addr [4];
   logic [2:0]  mem_op [4];
   logic [63:0] wdata [4];
   wire  [31:0] rd32 [3];
   wire  [63:0] rd64;
   logic [63:0] rdata [4];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb [4][$];
   bit   seen [4];
   logic [7:0] mdl [longint unsigned];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_x32
      lsu_data_mem #(.XLEN(32), .DEPTH(DEPTH), .LATENCY(g == 0 ? 1 : g + 2), .BASE_ADDR(BASE)) u_dut (
         .Clk(clk), .Rst_n(rst_n[g]), .ReqValid(req_valid[g]), .ReqReady(req_ready[g]),
         .ReqAddr(req_addr[g]), .ReqWr(req_wr[g]), .MemOp(mem_op[g]), .ReqWData(wdata[g][31:0]),
         .RspValid(rsp_valid[g]), .RspReady(rsp_ready[g]), .RspRData(rd32[g]), .RspFault(rsp_fault[g])
      );
   end

   lsu_data_mem #(.XLEN(64), .DEPTH(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) u_dut64 (
      .Clk(clk), .Rst_n(rst_n[3]), .ReqValid(req_valid[3]), .ReqReady(req_ready[3]),
      .ReqAddr(req_addr[3]), .ReqWr(req_wr[3]), .MemOp(mem_op[3]), .ReqWData(wdata[3]),
      .RspValid(rsp_valid[3]), .RspReady(rsp_ready[3]), .RspRData(rd64), .RspFault(rsp_fault[3])
   );

   always_comb begin
      for (int i = 0; i < 3; i++) rdata[i] = {32'h0, rd32[i]};
      rdata[3] = rd64;
   end

   function automatic int xl(input int i);
      return (i == 3) ? 64 : 32;
   endfunction

   function automatic int lat(input int i);
      case (i)
         0: return 1;
         1: return 3;
         2: return 4;
         default: return 2;
      endcase
   endfunction

   // Reference: byte-addressed little-endian memory with the access rules applied directly.
   function automatic void model(input int i, input logic wr, input logic [2:0] op,
                                 input logic [31:0] a, input logic [63:0] wd,
                                 output logic [63:0] rd, output logic f);
      int unsigned nb, sz;
      logic [31:0] off;
      logic ill, mis, oor;
      longint unsigned k;
      nb  = xl(i) / 8;
      sz  = 1 << op[1:0];
      off = a - BASE;
      ill = (xl(i) == 32 && op[1:0] == 2'd3) || (op[2] && wr) || (op[2] && sz == nb);
      mis = (off % sz) != 0;
      oor = (a < BASE) || ((off / nb) >= DEPTH);
      f   = ill || mis || oor;
      rd  = '0;
      if (f) return;
      for (int b = 0; b < int'(sz); b++) begin
         k = {32'(i), a + 32'(b)};
         if (wr) mdl[k] = wd[8*b +: 8];
         else    rd[8*b +: 8] = mdl.exists(k) ? mdl[k] : 8'h00;
      end
      if (!wr && !op[2] && rd[8*sz-1]) begin
         for (int b = 8 * int'(sz); b < xl(i); b++) rd[b] = 1'b1;
      end
   endfunction

   // Every cycle: reset outputs, response latency, response contents, then capture new accepts.
   always @(negedge clk) begin
      logic [63:0] erd;
      logic        ef;
      exp_t        e;
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (!rst_n[i]) begin
            sb[i].delete();
            seen[i] = 1'b0;
            checks++;
            if (rsp_valid[i] !== 1'b0 || req_ready[i] !== 1'b0) begin
               errors++;
               $display("FAIL in_reset[%0d]: rsp_valid=%b req_ready=%b, required 0 0",
                        i, rsp_valid[i], req_ready[i]);
            end
         end else begin
            if (rsp_valid[i]) begin
               checks++;
               if (sb[i].size() == 0) begin
                  errors++;
                  $display("FAIL spurious_rsp[%0d]: RspValid=1 with nothing outstanding", i);
               end else begin
                  if (!seen[i]) begin
                     seen[i] = 1'b1;
                     checks++;
                     if (cyc - sb[i][0].acc != lat(i)) begin
                        errors++;
                        $display("FAIL latency[%0d]: %0d cycles, required %0d",
                                 i, cyc - sb[i][0].acc, lat(i));
                     end
                  end
                  if (rdata[i] !== sb[i][0].rd || rsp_fault[i] !== sb[i][0].f) begin
                     errors++;
                     $display("FAIL rsp[%0d] @%0d: rdata=%h fault=%b, required rdata=%h fault=%b",
                              i, cyc, rdata[i], rsp_fault[i], sb[i][0].rd, sb[i][0].f);
                  end
                  if (rsp_ready[i]) begin
                     void'(sb[i].pop_front());
                     seen[i] = 1'b0;
                  end
               end
            end
            if (req_valid[i] && req_ready[i]) begin
               model(i, req_wr[i], mem_op[i], req_addr[i], wdata[i], erd, ef);
               e.rd  = erd;
               e.f   = ef;
               e.acc = cyc;
               sb[i].push_back(e);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic timeout(input string nm, input int i);
      checks++;
      errors++;
      $display("FAIL timeout_%s[%0d]: no handshake within 20 cycles", nm, i);
   endtask

   task automatic do_req(input int i, input logic wr, input logic [2:0] op, input logic [31:0] a,
                         input logic [63:0] wd, output logic [63:0] rd, output logic f);
      int n;
      rd = '0;
      f  = 1'b0;
      @(posedge clk); #1;
      req_valid[i] = 1'b1; req_wr[i] = wr; mem_op[i] = op;
      req_addr[i]  = a;    wdata[i]  = wd; rsp_ready[i] = 1'b1;
      n = 0;
      @(negedge clk);
      while (!req_ready[i]) begin
         n++;
         if (n > 20) begin
            timeout("accept", i);
            req_valid[i] = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
      n = 0;
      @(negedge clk);
      while (!rsp_valid[i]) begin
         n++;
         if (n > 20) begin
            timeout("response", i);
            return;
         end
         @(negedge clk);
      end
      rd = rdata[i];
      f  = rsp_fault[i];
   endtask

   task automatic wait_rsp(input int i);
      int n;
      n = 0;
      @(negedge clk);
      while (!rsp_valid[i]) begin
         n++;
         if (n > 20) begin
            timeout("wait_rsp", i);
            return;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rd;
      logic        f;
      rst_n     = 4'b0000;
      req_valid = 4'b0000;
      req_wr    = 4'b0000;
      rsp_ready = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         req_addr[i] = BASE;
         mem_op[i]   = OP_W;
         wdata[i]    = '0;
      end

      #12;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset_rdata[%0d]", i), rdata[i], 64'h0);
         chk($sformatf("reset_fault[%0d]", i), 64'(rsp_fault[i]), 64'h0);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 4'b1111;

      // XLEN 32, LATENCY 1: sign/zero extension and byte-masked store
      do_req(0, 1'b1, OP_W,  32'h8000_0004, 64'hDEAD_BEEF, rd, f);
      do_req(0, 1'b0, OP_B,  32'h8000_0007, 64'h0, rd, f);
      chk("lb_sext", rd, 64'hFFFF_FFDE);
      chk("lb_fault", 64'(f), 64'h0);
      do_req(0, 1'b0, OP_BU, 32'h8000_0007, 64'h0, rd, f);
      chk("lbu_zext", rd, 64'h0000_00DE);
      do_req(0, 1'b1, OP_W,  32'h8000_0000, 64'h1122_3344, rd, f);
      do_req(0, 1'b1, OP_H,  32'h8000_0002, 64'h0000_AABB, rd, f);
      do_req(0, 1'b0, OP_W,  32'h8000_0000, 64'h0, rd, f);
      chk("sh_masked", rd, 64'hAABB_3344);

      // Faults: misaligned, out of range, illegal ops
      do_req(0, 1'b0, OP_W,  32'h8000_0002, 64'h0, rd, f);
      chk("misaligned_lw_fault", 64'(f), 64'h1);
      chk("misaligned_lw_data", rd, 64'h0);
      do_req(0, 1'b1, OP_H,  32'h8000_0001, 64'h0000_FFFF, rd, f);
      chk("misaligned_sh_fault", 64'(f), 64'h1);
      do_req(0, 1'b0, OP_W,  32'h8000_0000, 64'h0, rd, f);
      chk("misaligned_sh_nowrite", rd, 64'hAABB_3344);
      do_req(0, 1'b0, OP_W,  32'h7FFF_FFFC, 64'h0, rd, f);
      chk("below_base_fault", 64'(f), 64'h1);
      do_req(0, 1'b0, OP_W,  32'h8000_1000, 64'h0, rd, f);
      chk("past_depth_fault", 64'(f), 64'h1);
      do_req(0, 1'b1, OP_W,  32'h8000_0FFC, 64'h0A0B_0C0D, rd, f);
      do_req(0, 1'b0, OP_W,  32'h8000_0FFC, 64'h0, rd, f);
      chk("last_word", rd, 64'h0A0B_0C0D);
      chk("last_word_fault", 64'(f), 64'h0);
      do_req(0, 1'b0, OP_D,  32'h8000_0000, 64'h0, rd, f);
      chk("op_d_x32_fault", 64'(f), 64'h1);
      do_req(0, 1'b1, OP_BU, 32'h8000_0000, 64'h0000_0099, rd, f);
      chk("unsigned_store_fault", 64'(f), 64'h1);
      do_req(0, 1'b0, OP_WU, 32'h8000_0000, 64'h0, rd, f);
      chk("lwu_x32_fault", 64'(f), 64'h1);
      do_req(0, 1'b0, OP_W,  32'h8000_0000, 64'h0, rd, f);
      chk("faulted_stores_nowrite", rd, 64'hAABB_3344);

      // LATENCY 3: response timing, backpressure, accept on the handshake edge
      do_req(1, 1'b1, OP_W, 32'h8000_0010, 64'hCAFE_F00D, rd, f);
      @(posedge clk); #1;
      req_valid[1] = 1'b1; req_wr[1] = 1'b0; mem_op[1] = OP_W;
      req_addr[1]  = 32'h8000_0010; rsp_ready[1] = 1'b0;
      @(negedge clk);
      chk("bp_ready_idle", 64'(req_ready[1]), 64'h1);
      @(posedge clk); #1;
      mem_op[1] = OP_HU; req_addr[1] = 32'h8000_0012;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk($sformatf("bp_valid_c%0d", k), 64'(rsp_valid[1]), (k == 3) ? 64'h1 : 64'h0);
         if (k < 3) chk($sformatf("bp_wait_ready_c%0d", k), 64'(req_ready[1]), 64'h0);
      end
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("bp_hold_valid", 64'(rsp_valid[1]), 64'h1);
         chk("bp_hold_data", rdata[1], 64'hCAFE_F00D);
         chk("bp_hold_ready", 64'(req_ready[1]), 64'h0);
      end
      @(posedge clk); #1;
      rsp_ready[1] = 1'b1;
      @(negedge clk);
      chk("bp_ready_follows_rspready", 64'(req_ready[1]), 64'h1);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(negedge clk);
      chk("bp_b2b_wait", 64'(rsp_valid[1]), 64'h0);
      wait_rsp(1);
      chk("bp_b2b_data", rdata[1], 64'h0000_CAFE);

      // LATENCY 4: reset while a store is in flight
      @(posedge clk); #1;
      req_valid[2] = 1'b1; req_wr[2] = 1'b1; mem_op[2] = OP_W;
      req_addr[2]  = 32'h8000_0020; wdata[2] = 64'h55AA_55AA; rsp_ready[2] = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      rst_n[2] = 1'b0;
      #1;
      chk("rst_wait_valid", 64'(rsp_valid[2]), 64'h0);
      chk("rst_wait_ready", 64'(req_ready[2]), 64'h0);
      repeat (2) @(posedge clk);
      #1 rst_n[2] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("rst_no_response", 64'(rsp_valid[2]), 64'h0);
      end
      do_req(2, 1'b0, OP_W, 32'h8000_0020, 64'h0, rd, f);
      chk("rst_store_committed", rd, 64'h55AA_55AA);

      // Reset while a response is being presented drops RspValid without a clock
      @(posedge clk); #1;
      req_valid[2] = 1'b1; req_wr[2] = 1'b0; mem_op[2] = OP_W;
      req_addr[2]  = 32'h8000_0020; rsp_ready[2] = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      wait_rsp(2);
      chk("rsp_before_reset", 64'(rsp_valid[2]), 64'h1);
      #3 rst_n[2] = 1'b0;
      #1;
      chk("rst_async_drop", 64'(rsp_valid[2]), 64'h0);
      chk("rst_async_rdata", rdata[2], 64'h0);
      repeat (2) @(posedge clk);
      #1 rst_n[2] = 1'b1; rsp_ready[2] = 1'b1;

      // XLEN 64, LATENCY 2
      do_req(3, 1'b1, OP_D,  32'h8000_0008, 64'h0123_4567_89AB_CDEF, rd, f);
      do_req(3, 1'b0, OP_WU, 32'h8000_000C, 64'h0, rd, f);
      chk("x64_lwu", rd, 64'h0000_0000_0123_4567);
      do_req(3, 1'b0, OP_W,  32'h8000_0008, 64'h0, rd, f);
      chk("x64_lw", rd, 64'hFFFF_FFFF_89AB_CDEF);
      do_req(3, 1'b0, OP_B,  32'h8000_000B, 64'h0, rd, f);
      chk("x64_lb", rd, 64'hFFFF_FFFF_FFFF_FF89);
      do_req(3, 1'b0, OP_H,  32'h8000_000E, 64'h0, rd, f);
      chk("x64_lh", rd, 64'h0000_0000_0000_0123);
      do_req(3, 1'b0, OP_D,  32'h8000_0008, 64'h0, rd, f);
      chk("x64_ld", rd, 64'h0123_4567_89AB_CDEF);
      do_req(3, 1'b0, 3'b111, 32'h8000_0008, 64'h0, rd, f);
      chk("x64_ldu_fault", 64'(f), 64'h1);
      do_req(3, 1'b0, OP_W,  32'h8000_000A, 64'h0, rd, f);
      chk("x64_misaligned_fault", 64'(f), 64'h1);
      chk("x64_misaligned_data", rd, 64'h0);

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
